// File: rtl/hazard_ctrl.sv
// Load-use / multi-cycle / branch hazard controller between ID and EX.
// Stalls the front end for LOAD_LAT cycles after a load-use hit and counts stall cycles.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal issue; load-use, mc_busy and branch decoded each cycle
// LD_STALL | remaining load-use bubbles; cnt is the number left minus one
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_branch_taken,
    input  logic              mc_busy,
    output logic              pc_write_en,
    output logic              if_id_write_en,
    output logic              id_ex_write_en,
    output logic              id_ex_bubble,
    output logic              flush_if_id,
    output logic              load_stall,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic {
        RUN      = 1'b0,
        LD_STALL = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       hz;

    // x0 is hard-wired zero, so a load targeting it can never create a hazard
    assign hz = ex_memread && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= 4'd0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load_stall && (stall_cycles != PERF_MAX))
                stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        id_ex_write_en = 1'b1;
        id_ex_bubble   = 1'b0;
        flush_if_id    = 1'b0;
        load_stall     = 1'b0;

        if (ex_branch_taken) begin
            // Fetch still advances; the flush discards the wrong-path instruction
            flush_if_id  = 1'b1;
            id_ex_bubble = 1'b1;
            state_nxt    = RUN;
            cnt_nxt      = (state == LD_STALL) ? 4'd0 : cnt;
        end else if (mc_busy) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_write_en = 1'b0;
        end else if ((state == LD_STALL) || hz) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
            load_stall     = 1'b1;
            if (state == RUN) begin
                if (LOAD_LAT > 1) begin
                    state_nxt = LD_STALL;
                    cnt_nxt   = CNT_INIT;
                end
            end else if (cnt == 4'd0) begin
                state_nxt = RUN;
            end else begin
                cnt_nxt = cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three instances with different LOAD_LAT/PERF_W share
// the stimulus; each directed vector names the instance whose outputs it checks.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken, mc_busy;

    always #5 clk = ~clk;

    // control bundle order: {pc, if_id, id_ex, bubble, flush, load_stall}
    localparam logic [5:0] O_RUN   = 6'b111000;
    localparam logic [5:0] O_STALL = 6'b001101;
    localparam logic [5:0] O_HOLD  = 6'b000000;
    localparam logic [5:0] O_FLUSH = 6'b111110;

    logic [5:0]  ctl1, ctl3, ctl4;
    logic [15:0] sc1, sc3;
    logic [2:0]  sc4;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .PERF_W(16)) u_lat1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken), .mc_busy(mc_busy),
        .pc_write_en(ctl1[5]), .if_id_write_en(ctl1[4]), .id_ex_write_en(ctl1[3]),
        .id_ex_bubble(ctl1[2]), .flush_if_id(ctl1[1]), .load_stall(ctl1[0]),
        .stall_cycles(sc1));

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .PERF_W(16)) u_lat3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken), .mc_busy(mc_busy),
        .pc_write_en(ctl3[5]), .if_id_write_en(ctl3[4]), .id_ex_write_en(ctl3[3]),
        .id_ex_bubble(ctl3[2]), .flush_if_id(ctl3[1]), .load_stall(ctl3[0]),
        .stall_cycles(sc3));

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(4), .PERF_W(3)) u_lat4 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken), .mc_busy(mc_busy),
        .pc_write_en(ctl4[5]), .if_id_write_en(ctl4[4]), .id_ex_write_en(ctl4[3]),
        .id_ex_bubble(ctl4[2]), .flush_if_id(ctl4[1]), .load_stall(ctl4[0]),
        .stall_cycles(sc4));

    typedef struct {
        int          sel;
        int          idx;
        logic        chk;
        logic [5:0]  ctl;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   vec_n  = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [5:0]  a_ctl;
            logic [15:0] a_sc;
            e = exp_q.pop_front();
            case (e.sel)
                1:       begin a_ctl = ctl1; a_sc = sc1; end
                3:       begin a_ctl = ctl3; a_sc = sc3; end
                default: begin a_ctl = ctl4; a_sc = {13'd0, sc4}; end
            endcase
            if (e.chk) begin
                checks++;
                if (a_ctl !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl lat%0d vec%0d: got %b expected %b", e.sel, e.idx, a_ctl, e.ctl);
                end
                checks++;
                if (a_sc !== e.sc) begin
                    errors++;
                    $display("FAIL stall_cycles lat%0d vec%0d: got %0d expected %0d", e.sel, e.idx, a_sc, e.sc);
                end
            end
        end
    end

    task automatic step(input int sel, input logic r, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic mc, input logic chk,
                        input logic [5:0] ctl, input logic [15:0] sc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        ex_rd = rd; ex_memread = mr; ex_branch_taken = br; mc_busy = mc;
        vec_n++;
        e.sel = sel; e.idx = vec_n; e.chk = chk; e.ctl = ctl; e.sc = sc;
        exp_q.push_back(e);
    endtask

    task automatic reset_cyc();
        step(1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 16'd0);
    endtask

    task automatic idle(input int sel, input logic [5:0] ctl, input logic [15:0] sc);
        step(sel, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, ctl, sc);
    endtask

    // load to x5 in EX, ID reads x5 through rs1
    task automatic hzd(input int sel, input logic br, input logic mc,
                       input logic [5:0] ctl, input logic [15:0] sc);
        step(sel, 1'b0, 5'd5, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, br, mc, 1'b1, ctl, sc);
    endtask

    initial begin
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
        ex_branch_taken = 1'b0; mc_busy = 1'b0;

        reset_cyc();
        reset_cyc();
        idle(1, O_RUN, 16'd0);
        idle(3, O_RUN, 16'd0);
        idle(4, O_RUN, 16'd0);

        // LOAD_LAT=1: single bubble
        hzd(1, 1'b0, 1'b0, O_STALL, 16'd0);
        idle(1, O_RUN, 16'd1);
        idle(1, O_RUN, 16'd1);
        // x0 never hazards; unused rs2 ignored
        step(1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, O_RUN, 16'd1);
        step(1, 1'b0, 5'd3, 1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, O_RUN, 16'd1);
        // rs1 matches but is unused
        step(1, 1'b0, 5'd5, 1'b0, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, O_RUN, 16'd1);
        // hazard through rs2
        step(1, 1'b0, 5'd3, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, O_STALL, 16'd1);
        idle(1, O_RUN, 16'd2);
        // priorities in RUN
        hzd(1, 1'b0, 1'b1, O_HOLD, 16'd2);
        hzd(1, 1'b1, 1'b1, O_FLUSH, 16'd2);
        idle(1, O_RUN, 16'd2);

        // LOAD_LAT=3: three consecutive stall cycles, hz not re-evaluated
        reset_cyc();
        hzd(3, 1'b0, 1'b0, O_STALL, 16'd0);
        idle(3, O_STALL, 16'd1);
        idle(3, O_STALL, 16'd2);
        idle(3, O_RUN, 16'd3);
        idle(3, O_RUN, 16'd3);

        // LOAD_LAT=4: branch in second stall cycle aborts the stall
        reset_cyc();
        hzd(4, 1'b0, 1'b0, O_STALL, 16'd0);
        step(4, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, O_FLUSH, 16'd1);
        idle(4, O_RUN, 16'd1);
        idle(4, O_RUN, 16'd1);

        // LOAD_LAT=4: mc_busy freezes LD_STALL at cnt=1 for 5 cycles
        reset_cyc();
        hzd(4, 1'b0, 1'b0, O_STALL, 16'd0);
        idle(4, O_STALL, 16'd1);
        for (int i = 0; i < 5; i++)
            step(4, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, O_HOLD, 16'd2);
        idle(4, O_STALL, 16'd2);
        idle(4, O_STALL, 16'd3);
        idle(4, O_RUN, 16'd4);

        // PERF_W=3: 9 back-to-back stall cycles saturate at 7, then reset mid-stall
        reset_cyc();
        for (int i = 0; i < 9; i++)
            hzd(4, 1'b0, 1'b0, O_STALL, 16'((i > 7) ? 7 : i));
        idle(4, O_STALL, 16'd7);
        reset_cyc();
        idle(4, O_RUN, 16'd0);
        idle(4, O_RUN, 16'd0);

        @(posedge clk);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the 5-stage RISC-V core, sitting between the ID and EX stages.
- Detects load-use hazards and stalls for a configurable number of load-latency cycles using an internal FSM and counter.
- Freezes the front end while a multi-cycle EX unit is busy, and flushes IF/ID and ID/EX on a taken branch.
- Keeps a saturating performance counter of load-use stall cycles.

Parameters:
- REG_AW, 5: register address width.
- LOAD_LAT, 1: load-use bubble cycles, legal range 1..15.
- PERF_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_rs1  in  REG_AW  source register 1 of the instruction in ID
- id_rs2  in  REG_AW  source register 2 of the instruction in ID
- id_use_rs1  in  1  ID instruction actually reads rs1
- id_use_rs2  in  1  ID instruction actually reads rs2
- ex_rd  in  REG_AW  destination register of the instruction in EX
- ex_memread  in  1  instruction in EX is a load
- ex_branch_taken  in  1  taken branch/jump resolved in EX this cycle
- mc_busy  in  1  multi-cycle EX unit (mul/div) not yet done
- pc_write_en  out  1  PC update enable
- if_id_write_en  out  1  IF/ID register enable
- id_ex_write_en  out  1  ID/EX register enable
- id_ex_bubble  out  1  load zeroed controls into ID/EX (NOP)
- flush_if_id  out  1  clear IF/ID
- load_stall  out  1  a load-use stall is in effect this cycle
- stall_cycles  out  PERF_W  saturating count of load_stall cycles

Behaviour:
- Hazard term hz = ex_memread & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
  - Register 0 never causes a hazard.
  - Unused source fields are ignored.
- FSM states: RUN, LD_STALL. Down-counter cnt is 4 bits wide.
- Priority, highest first: rst > ex_branch_taken > mc_busy > load-use.
- RUN, ex_branch_taken=1:
  - flush_if_id=1, id_ex_bubble=1, pc_write_en=1, if_id_write_en=1 (the fetch is discarded by the flush), id_ex_write_en=1.
  - Stay in RUN; hz is ignored.
- RUN, mc_busy=1 (no branch):
  - pc_write_en=0, if_id_write_en=0, id_ex_write_en=0 (hold, not bubble), id_ex_bubble=0.
  - load_stall=0; stay in RUN.
- RUN, hz=1:
  - Combinational in the detection cycle: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, id_ex_write_en=1, load_stall=1.
  - If LOAD_LAT>1: next state LD_STALL, cnt<=LOAD_LAT-2. Otherwise stay in RUN.
- RUN, otherwise: all enables 1, bubble/flush 0.
- LD_STALL:
  - Same outputs as the hz cycle; hz is not re-evaluated.
  - If cnt==0, go to RUN; otherwise cnt<=cnt-1.
  - Total stall length is exactly LOAD_LAT cycles.
- LD_STALL, ex_branch_taken=1: flush outputs as in RUN, load_stall=0, go to RUN, cnt<=0 (stall aborted).
- LD_STALL, mc_busy=1: treated as a hold. All enables 0, state and cnt frozen, load_stall=0.
- stall_cycles increments by 1 on every clock where load_stall=1, and saturates at all-ones (no wrap).
- Reset, including mid-stall: state=RUN, cnt=0, stall_cycles=0.
  - Outputs then follow RUN decode of the current inputs; with idle inputs, all enables are 1 and bubble/flush/load_stall are 0.
- Output latency: all control outputs are combinational from inputs and registered state. Only state, cnt and stall_cycles are registered.

Test Plan:
- LOAD_LAT=1; ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> exactly 1 cycle with pc_write_en=0, id_ex_bubble=1; stall_cycles=1.
- LOAD_LAT=3; same hazard, then ex_memread=0 (bubble in EX) -> load_stall high 3 consecutive cycles, then RUN; stall_cycles=3.
- ex_rd=0 with id_rs1=0, or id_use_rs2=0 with id_rs2==ex_rd -> no stall; all enables 1.
- LOAD_LAT=4; branch taken in the 2nd LD_STALL cycle -> flush_if_id=1, id_ex_bubble=1, load_stall=0 that cycle; RUN next cycle; stall_cycles=1.
- mc_busy=1 for 5 cycles while in LD_STALL with cnt=1 -> all enables 0 for 5 cycles, cnt unchanged, stall resumes afterwards; total load_stall cycles = LOAD_LAT.
- PERF_W=3; 9 back-to-back stall cycles -> stall_cycles saturates at 7. rst asserted mid-LD_STALL -> next cycle stall_cycles=0, state RUN.
